// File: rtl/mcp320x_pkg.sv
// Shared types, constants and helpers for the MCP320x scanning SPI master.
package mcp320x_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SETUP = 2'd1,
    ST_SHIFT = 2'd2,
    ST_GAP   = 2'd3
  } scan_state_t;

  localparam int CMD_BITS  = 5;
  localparam int NULL_EDGE = 7;

  function automatic int frame_len(input int res);
    return 7 + res;
  endfunction

  function automatic logic [2:0] lowest_set(input logic [7:0] mask);
    logic [2:0] idx;
    idx = '0;
    for (int i = 7; i >= 0; i--) begin
      if (mask[i]) idx = 3'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/mcp320x_frame.sv
// One chip-select-low frame: SCLK divider, half-period counter, command
// shifter, synchronized receive shifter and null-bit check.
module mcp320x_frame
  import mcp320x_pkg::*;
#(
  parameter int CLKDIV = 4,
  parameter int RES    = 12
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                i_start,
  input  logic [CMD_BITS-1:0] i_cmd,
  input  logic [2:0]          i_chan,
  input  logic                i_dout,
  output logic                o_cs_n,
  output logic                o_sclk,
  output logic                o_din,
  output logic                o_in_shift,
  output logic                o_done,
  output logic [2:0]          o_chan,
  output logic [RES-1:0]      o_data,
  output logic                o_err
);

  localparam int N  = frame_len(RES);
  localparam int HW = $clog2(2 * N + 1);
  localparam int DW = $clog2(CLKDIV);
  localparam logic [HW-1:0] LAST_HALF = HW'(2 * N - 1);

  logic                r_sync1, r_sync2;
  logic                r_active, r_null;
  logic                r_cs_n, r_sclk, r_din, r_done, r_err;
  logic [DW-1:0]       r_div;
  logic [HW-1:0]       r_half;
  logic [HW-1:0]       w_edge;
  logic [CMD_BITS-1:0] r_cmd;
  logic [RES-1:0]      r_shift, r_data;
  logic [RES-1:0]      w_shift_nxt;
  logic [2:0]          r_chan, r_ochan;

  // Half-period h ends on an odd index => the rising edge (h+1)/2 is being sampled.
  assign w_edge      = (r_half + 1'b1) >> 1;
  assign w_shift_nxt = {r_shift[RES-2:0], r_sync2};

  assign o_cs_n     = r_cs_n;
  assign o_sclk     = r_sclk;
  assign o_din      = r_din;
  assign o_in_shift = r_active && (r_half != '0);
  assign o_done     = r_done;
  assign o_chan     = r_ochan;
  assign o_data     = r_data;
  assign o_err      = r_err;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1  <= 1'b0;
      r_sync2  <= 1'b0;
      r_active <= 1'b0;
      r_null   <= 1'b0;
      r_cs_n   <= 1'b1;
      r_sclk   <= 1'b0;
      r_din    <= 1'b0;
      r_done   <= 1'b0;
      r_err    <= 1'b0;
      r_div    <= '0;
      r_half   <= '0;
      r_cmd    <= '0;
      r_shift  <= '0;
      r_data   <= '0;
      r_chan   <= '0;
      r_ochan  <= '0;
    end else begin
      r_sync1 <= i_dout;
      r_sync2 <= r_sync1;
      r_done  <= 1'b0;
      if (!r_active) begin
        if (i_start) begin
          r_active <= 1'b1;
          r_cs_n   <= 1'b0;
          r_din    <= i_cmd[CMD_BITS-1];
          r_cmd    <= i_cmd;
          r_chan   <= i_chan;
          r_div    <= DW'(CLKDIV - 1);
          r_half   <= '0;
          r_null   <= 1'b0;
        end
      end else if (r_div != '0) begin
        r_div <= r_div - 1'b1;
      end else begin
        r_div  <= DW'(CLKDIV - 1);
        r_half <= r_half + 1'b1;
        if (!r_half[0]) begin
          r_sclk <= 1'b1;
        end else begin
          r_sclk <= 1'b0;
          if (w_edge == HW'(NULL_EDGE)) r_null <= r_sync2;
          if (w_edge > HW'(NULL_EDGE)) r_shift <= w_shift_nxt;
          if (r_half == LAST_HALF) begin
            r_active <= 1'b0;
            r_cs_n   <= 1'b1;
            r_din    <= 1'b0;
            r_done   <= 1'b1;
            r_data   <= w_shift_nxt;
            r_err    <= r_null;
            r_ochan  <= r_chan;
          end else begin
            r_cmd <= {r_cmd[CMD_BITS-2:0], 1'b0};
            r_din <= r_cmd[CMD_BITS-2];
          end
        end
      end
    end
  end

endmodule

// File: rtl/mcp320x_scan.sv
// Scan sequencer for MCP320x ADCs: walks the latched channel mask in
// ascending order and launches one frame per channel.
//   state    | meaning
//   ST_IDLE  | waiting for start/auto with a non-empty mask
//   ST_SETUP | frame launched, CS low before the first SCLK rise
//   ST_SHIFT | SCLK running, command out / data in
//   ST_GAP   | CS high between frames, then next channel, rescan or idle
module mcp320x_scan
  import mcp320x_pkg::*;
#(
  parameter int NCH     = 8,
  parameter int RES     = 12,
  parameter int CLKDIV  = 4,
  parameter int CS_IDLE = 8
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           start,
  input  logic           auto,
  input  logic [NCH-1:0] chan_mask,
  input  logic [NCH-1:0] diff_mask,
  output logic           adc_cs_n,
  output logic           adc_sclk,
  output logic           adc_din,
  input  logic           adc_dout,
  output logic           busy,
  output logic           res_valid,
  output logic [2:0]     res_chan,
  output logic [RES-1:0] res_data,
  output logic           res_err
);

  // Gap length absorbs the launch and frame-start register stages so that
  // CS stays high for CS_IDLE + CLKDIV cycles between frames.
  localparam int GAP_LOAD = CS_IDLE + CLKDIV - 3;
  localparam int GW       = $clog2(CS_IDLE + CLKDIV);

  scan_state_t         r_state;
  logic [7:0]          r_pend, r_diff;
  logic [2:0]          r_chan;
  logic [CMD_BITS-1:0] r_cmd;
  logic                r_frame_start, r_busy;
  logic [GW-1:0]       r_gap;

  logic [7:0] w_cm8, w_dm8, w_src_mask, w_src_diff;
  logic [2:0] w_first;
  logic       w_use_live, w_launch, w_in_shift, w_done;

  function automatic logic [CMD_BITS-1:0] make_cmd(input logic diff, input logic [2:0] ch);
    return {1'b1, ~diff, (NCH == 4) ? 1'b0 : ch[2], ch[1:0]};
  endfunction

  always_comb begin
    w_cm8 = '0;
    w_cm8[NCH-1:0] = chan_mask;
    w_dm8 = '0;
    w_dm8[NCH-1:0] = diff_mask;
    w_use_live = (r_state == ST_IDLE) || (r_pend == '0);
    w_src_mask = w_use_live ? w_cm8 : r_pend;
    w_src_diff = w_use_live ? w_dm8 : r_diff;
    w_first    = lowest_set(w_src_mask);
    w_launch   = ((r_state == ST_IDLE) && (start || auto) && (w_cm8 != '0)) ||
                 ((r_state == ST_GAP) && (r_gap == '0) &&
                  ((r_pend != '0) || (auto && (w_cm8 != '0))));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= ST_IDLE;
      r_pend        <= '0;
      r_diff        <= '0;
      r_chan        <= '0;
      r_cmd         <= '0;
      r_frame_start <= 1'b0;
      r_busy        <= 1'b0;
      r_gap         <= '0;
    end else begin
      r_frame_start <= 1'b0;
      if (w_launch) begin
        r_pend        <= w_src_mask & ~(8'b1 << w_first);
        r_diff        <= w_src_diff;
        r_chan        <= w_first;
        r_cmd         <= make_cmd(w_src_diff[w_first], w_first);
        r_frame_start <= 1'b1;
        r_busy        <= 1'b1;
        r_state       <= ST_SETUP;
      end else begin
        case (r_state)
          ST_IDLE: ;
          ST_SETUP: if (w_in_shift) r_state <= ST_SHIFT;
          ST_SHIFT: begin
            if (w_done) begin
              r_state <= ST_GAP;
              r_gap   <= GW'(GAP_LOAD);
            end
          end
          ST_GAP: begin
            if (r_gap != '0) begin
              r_gap <= r_gap - 1'b1;
            end else begin
              r_state <= ST_IDLE;
              r_busy  <= 1'b0;
            end
          end
          default: r_state <= ST_IDLE;
        endcase
      end
    end
  end

  mcp320x_frame #(
    .CLKDIV(CLKDIV),
    .RES   (RES)
  ) u_frame (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_start   (r_frame_start),
    .i_cmd     (r_cmd),
    .i_chan    (r_chan),
    .i_dout    (adc_dout),
    .o_cs_n    (adc_cs_n),
    .o_sclk    (adc_sclk),
    .o_din     (adc_din),
    .o_in_shift(w_in_shift),
    .o_done    (w_done),
    .o_chan    (res_chan),
    .o_data    (res_data),
    .o_err     (res_err)
  );

  assign busy      = r_busy;
  assign res_valid = w_done;

endmodule

// File: tb/tb_mcp320x_scan.sv
// Self-checking bench for mcp320x_scan: behavioral ADC models, a table of
// scan vectors and hand-written sequences for auto, abort and no-op cases.
module tb_mcp320x_scan;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       start = 1'b0, auto = 1'b0;
  logic [7:0] chan_mask = '0, diff_mask = '0;
  logic       adc_cs_n, adc_sclk, adc_din, adc_dout;
  logic       busy, res_valid, res_err;
  logic [2:0] res_chan;
  logic [11:0] res_data;

  logic       start_b = 1'b0;
  logic [3:0] mask_b = '0, diff_b = '0;
  logic       b_cs_n, b_sclk, b_din, b_busy, b_valid, b_err;
  logic [2:0] b_chan;
  logic [9:0] b_data;

  always #5 clk = ~clk;

  mcp320x_scan dut (
    .clk(clk), .rst_n(rst_n), .start(start), .auto(auto),
    .chan_mask(chan_mask), .diff_mask(diff_mask),
    .adc_cs_n(adc_cs_n), .adc_sclk(adc_sclk), .adc_din(adc_din), .adc_dout(adc_dout),
    .busy(busy), .res_valid(res_valid), .res_chan(res_chan),
    .res_data(res_data), .res_err(res_err)
  );

  mcp320x_scan #(.NCH(4), .RES(10), .CLKDIV(4), .CS_IDLE(8)) dut10 (
    .clk(clk), .rst_n(rst_n), .start(start_b), .auto(1'b0),
    .chan_mask(mask_b), .diff_mask(diff_b),
    .adc_cs_n(b_cs_n), .adc_sclk(b_sclk), .adc_din(b_din), .adc_dout(1'b1),
    .busy(b_busy), .res_valid(b_valid), .res_chan(b_chan),
    .res_data(b_data), .res_err(b_err)
  );

  int n_tests = 0, n_fail = 0;
  int cyc = 0;
  int null_ch = 8;

  typedef struct { logic [2:0] ch; logic [11:0] d; logic e; int cyc; } res_t;
  res_t       rq[$], bq[$];
  int         fall_q[$], rise_q[$], b_fall_q[$], b_rise_q[$], b_edge_q[$];
  logic [4:0] cmd_q[$], b_cmd_q[$];

  // ADC model for the 12-bit instance: returns 12'h111*(ch+1), optional null=1.
  int         a_bits = 0;
  logic [4:0] a_cmd = '0;
  logic       a_dout = 1'b0;
  logic [11:0] a_word;
  assign a_word   = 12'h111 * (12'(a_cmd[2:0]) + 12'd1);
  assign adc_dout = a_dout;

  always @(posedge adc_sclk or posedge adc_cs_n) begin
    if (adc_cs_n) begin
      if (a_bits != 0) cmd_q.push_back(a_cmd);
      a_bits = 0;
      a_cmd  = '0;
    end else begin
      a_bits++;
      if (a_bits <= 5) a_cmd = {a_cmd[3:0], adc_din};
    end
  end

  always @(negedge adc_sclk) begin
    if (a_bits == 6) a_dout = (int'(a_cmd[2:0]) == null_ch);
    else if (a_bits >= 7 && a_bits <= 18) a_dout = a_word[18 - a_bits];
    else a_dout = 1'b0;
  end

  int         b_bits = 0;
  logic [4:0] b_cmd = '0;
  always @(posedge b_sclk or posedge b_cs_n) begin
    if (b_cs_n) begin
      if (b_bits != 0) begin
        b_edge_q.push_back(b_bits);
        b_cmd_q.push_back(b_cmd);
      end
      b_bits = 0;
      b_cmd  = '0;
    end else begin
      b_bits++;
      if (b_bits <= 5) b_cmd = {b_cmd[3:0], b_din};
    end
  end

  logic a_prev_cs = 1'b1, b_prev_cs = 1'b1;
  always @(negedge clk) begin
    cyc++;
    if (a_prev_cs === 1'b1 && adc_cs_n === 1'b0) fall_q.push_back(cyc);
    if (a_prev_cs === 1'b0 && adc_cs_n === 1'b1) rise_q.push_back(cyc);
    a_prev_cs = adc_cs_n;
    if (b_prev_cs === 1'b1 && b_cs_n === 1'b0) b_fall_q.push_back(cyc);
    if (b_prev_cs === 1'b0 && b_cs_n === 1'b1) b_rise_q.push_back(cyc);
    b_prev_cs = b_cs_n;
    if (res_valid === 1'b1) rq.push_back('{res_chan, res_data, res_err, cyc});
    if (b_valid === 1'b1) bq.push_back('{b_chan, 12'(b_data), b_err, cyc});
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_start();
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
  endtask

  task automatic wait_scan(input int budget);
    bit seen, done;
    seen = 1'b0;
    done = 1'b0;
    for (int k = 0; k < budget && !done; k++) begin
      @(negedge clk);
      if (busy) seen = 1'b1;
      else if (seen) done = 1'b1;
    end
    chk("scan_done", 32'(done), 32'd1);
    tick(2);
  endtask

  typedef struct {
    logic [7:0]       mask;
    logic [7:0]       diff;
    int               nul;
    int               n;
    logic [3:0][2:0]  ch;
    logic [3:0][11:0] d;
    logic [3:0]       e;
    logic [3:0][4:0]  cmd;
  } vec_t;
  vec_t vecs[5];

  initial begin
    vecs[0] = '{8'hA5, 8'h00, 8, 4, {3'd7, 3'd5, 3'd2, 3'd0},
                {12'h888, 12'h666, 12'h333, 12'h111}, 4'b0000,
                {5'b11111, 5'b11101, 5'b11010, 5'b11000}};
    vecs[1] = '{8'h04, 8'h04, 8, 1, {3'd0, 3'd0, 3'd0, 3'd2},
                {12'h0, 12'h0, 12'h0, 12'h333}, 4'b0000,
                {5'b0, 5'b0, 5'b0, 5'b10010}};
    vecs[2] = '{8'h08, 8'h00, 3, 1, {3'd0, 3'd0, 3'd0, 3'd3},
                {12'h0, 12'h0, 12'h0, 12'h444}, 4'b0001,
                {5'b0, 5'b0, 5'b0, 5'b11011}};
    vecs[3] = '{8'h18, 8'h10, 3, 2, {3'd0, 3'd0, 3'd4, 3'd3},
                {12'h0, 12'h0, 12'h555, 12'h444}, 4'b0001,
                {5'b0, 5'b0, 5'b10100, 5'b11011}};
    vecs[4] = '{8'h80, 8'hFF, 8, 1, {3'd0, 3'd0, 3'd0, 3'd7},
                {12'h0, 12'h0, 12'h0, 12'h888}, 4'b0000,
                {5'b0, 5'b0, 5'b0, 5'b10111}};

    #2 rst_n = 1'b0;
    tick(3);
    chk("rst_cs_n", 32'(adc_cs_n), 32'd1);
    chk("rst_sclk", 32'(adc_sclk), 32'd0);
    chk("rst_din", 32'(adc_din), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_valid", 32'(res_valid), 32'd0);
    chk("rst_chan", 32'(res_chan), 32'd0);
    chk("rst_data", 32'(res_data), 32'd0);
    chk("rst_err", 32'(res_err), 32'd0);
    rst_n = 1'b1;
    tick(3);

    for (int v = 0; v < 5; v++) begin
      int r0, c0, f0, q0;
      r0 = rq.size(); c0 = cmd_q.size(); f0 = fall_q.size(); q0 = rise_q.size();
      chan_mask = vecs[v].mask;
      diff_mask = vecs[v].diff;
      null_ch   = vecs[v].nul;
      pulse_start();
      wait_scan(4000);
      chk($sformatf("v%0d_count", v), 32'(rq.size() - r0), 32'(vecs[v].n));
      for (int i = 0; i < vecs[v].n; i++) begin
        if (r0 + i < rq.size()) begin
          chk($sformatf("v%0d_s%0d_chan", v, i), 32'(rq[r0+i].ch), 32'(vecs[v].ch[i]));
          chk($sformatf("v%0d_s%0d_data", v, i), 32'(rq[r0+i].d), 32'(vecs[v].d[i]));
          chk($sformatf("v%0d_s%0d_err", v, i), 32'(rq[r0+i].e), 32'(vecs[v].e[i]));
        end
        if (c0 + i < cmd_q.size())
          chk($sformatf("v%0d_s%0d_cmd", v, i), 32'(cmd_q[c0+i]), 32'(vecs[v].cmd[i]));
      end
      if (v == 0) begin
        chk("v0_frames", 32'(fall_q.size() - f0), 32'd4);
        if (fall_q.size() >= f0 + 2 && rise_q.size() > q0 && rq.size() > r0) begin
          chk("cs_low_len", 32'(rise_q[q0] - fall_q[f0]), 32'd152);
          chk("strobe_cycle", 32'(rq[r0].cyc - fall_q[f0]), 32'd152);
          chk("frame_period", 32'(fall_q[f0+1] - fall_q[f0]), 32'd164);
          chk("cs_high_ge8", 32'((fall_q[f0+1] - rise_q[q0]) >= 8), 32'd1);
        end
      end
    end
    null_ch = 8;

    // 10-bit, 4-channel instance: 17 SCLK periods, D2 forced low.
    begin
      int r0, c0, f0, q0;
      bit done;
      r0 = bq.size(); c0 = b_cmd_q.size(); f0 = b_fall_q.size(); q0 = b_rise_q.size();
      mask_b = 4'b1000;
      @(negedge clk) start_b = 1'b1;
      @(negedge clk) start_b = 1'b0;
      done = 1'b0;
      for (int k = 0; k < 2000 && !done; k++) begin
        @(negedge clk);
        if (!b_busy) done = 1'b1;
      end
      chk("b_done", 32'(done), 32'd1);
      tick(2);
      chk("b_count", 32'(bq.size() - r0), 32'd1);
      if (bq.size() > r0) begin
        chk("b_chan", 32'(bq[r0].ch), 32'd3);
        chk("b_data", 32'(bq[r0].d), 32'h3FF);
        chk("b_err", 32'(bq[r0].e), 32'd1);
      end
      if (b_cmd_q.size() > c0) begin
        chk("b_sclk_edges", 32'(b_edge_q[c0]), 32'd17);
        chk("b_cmd", 32'(b_cmd_q[c0]), 32'b11011);
      end
      if (b_fall_q.size() > f0 && b_rise_q.size() > q0)
        chk("b_cs_low_len", 32'(b_rise_q[q0] - b_fall_q[f0]), 32'd136);
    end

    // Start during busy and mask change after acceptance: one frame only.
    begin
      int r0, f0;
      r0 = rq.size(); f0 = fall_q.size();
      chan_mask = 8'h01; diff_mask = 8'h00;
      pulse_start();
      tick(30);
      chan_mask = 8'hFF;
      pulse_start();
      wait_scan(2000);
      chk("busy_start_strobes", 32'(rq.size() - r0), 32'd1);
      chk("busy_start_frames", 32'(fall_q.size() - f0), 32'd1);
      if (rq.size() > r0) chk("busy_start_chan", 32'(rq[r0].ch), 32'd0);
    end

    // Auto mode: continuous 0,1,0,1; drop auto during a ch0 frame.
    begin
      int r0;
      bit seen_low;
      r0 = rq.size();
      chan_mask = 8'h03;
      @(negedge clk) auto = 1'b1;
      for (int k = 0; k < 2000 && rq.size() < r0 + 4; k++) @(negedge clk);
      chk("auto_four", 32'(rq.size() >= r0 + 4), 32'd1);
      seen_low = 1'b0;
      for (int k = 0; k < 400 && !seen_low; k++) begin
        @(negedge clk);
        if (!adc_cs_n) seen_low = 1'b1;
      end
      chk("auto_fifth_frame", 32'(seen_low), 32'd1);
      auto = 1'b0;
      wait_scan(2000);
      chk("auto_count", 32'(rq.size() - r0), 32'd6);
      for (int i = 0; i < 6; i++)
        if (r0 + i < rq.size())
          chk($sformatf("auto_s%0d_chan", i), 32'(rq[r0+i].ch), 32'(i % 2));
      if (rq.size() >= r0 + 3) begin
        chk("auto_s1_data", 32'(rq[r0+1].d), 32'h222);
        chk("auto_period_in", 32'(rq[r0+1].cyc - rq[r0].cyc), 32'd164);
        chk("auto_period_rescan", 32'(rq[r0+2].cyc - rq[r0+1].cyc), 32'd164);
      end
    end

    // Reset at cycle 60 of a frame: immediate CS high / SCLK low, no strobe.
    begin
      int r0;
      bit seen_low;
      r0 = rq.size();
      chan_mask = 8'h01;
      pulse_start();
      seen_low = 1'b0;
      for (int k = 0; k < 50 && !seen_low; k++) begin
        @(negedge clk);
        if (!adc_cs_n) seen_low = 1'b1;
      end
      chk("abort_frame_started", 32'(seen_low), 32'd1);
      tick(60);
      chk("sclk_high_c60", 32'(adc_sclk), 32'd1);
      #2 rst_n = 1'b0;
      #1;
      chk("abort_cs_n", 32'(adc_cs_n), 32'd1);
      chk("abort_sclk", 32'(adc_sclk), 32'd0);
      tick(5);
      chk("abort_busy", 32'(busy), 32'd0);
      rst_n = 1'b1;
      tick(400);
      chk("abort_no_strobe", 32'(rq.size() - r0), 32'd0);
    end

    // Empty mask: start is a no-op.
    begin
      int f0;
      bit seen_busy;
      f0 = fall_q.size();
      chan_mask = 8'h00;
      pulse_start();
      seen_busy = 1'b0;
      for (int k = 0; k < 300; k++) begin
        @(negedge clk);
        if (busy) seen_busy = 1'b1;
      end
      chk("mask0_busy", 32'(seen_busy), 32'd0);
      chk("mask0_frames", 32'(fall_q.size() - f0), 32'd0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1);
  end

endmodule

// File: doc/mcp320x_scan.md
# mcp320x_scan

Synthesizable SPI master for the MCP320x family of successive-approximation ADCs (MCP3204/3208 at 12 bits, MCP3004/3008 at 10 bits). It scans a masked set of channels in single-ended or differential mode, one-shot or free-running. It also checks the ADC null bit and emits one result per conversion on a strobe interface. It sits between the board-level ADC pins and the local register/readout logic, replacing ad-hoc bit-banged access.

## Interface
- `NCH`, 8: channel count, 4 or 8; mask widths follow it.
- `RES`, 12: conversion resolution in bits, 10 or 12.
- `CLKDIV`, 4: SCLK half-period in `clk` cycles, ≥2.
- `CS_IDLE`, 8: minimum `adc_cs_n` high time between frames, in `clk` cycles, ≥1.
- `clk`  in  1: single system clock; all logic on rising edge.
- `rst_n`  in  1: asynchronous, active-low reset.
- `start`  in  1: one-cycle request for one scan of `chan_mask`.
- `auto`  in  1: level; while high, scans repeat back-to-back.
- `chan_mask`  in  NCH: channels included in the scan.
- `diff_mask`  in  NCH: per channel, 1 = differential (SGL/DIFF bit 0), 0 = single-ended.
- `adc_cs_n`  out  1: ADC chip select.
- `adc_sclk`  out  1: ADC serial clock, idles low (SPI mode 0).
- `adc_din`  out  1: command bits to ADC.
- `adc_dout`  in  1: data from ADC; synchronized internally.
- `busy`  out  1: high from scan acceptance to final gap end.
- `res_valid`  out  1: one-cycle result strobe.
- `res_chan`  out  3: channel index of result.
- `res_data`  out  RES: conversion result, MSB first as received.
- `res_err`  out  1: null bit sampled as 1 in this frame.

## Operation
- Reset values: `adc_cs_n`=1, `adc_sclk`=0, `adc_din`=0, `busy`=0, `res_valid`=0, `res_chan`=0, `res_data`=0, `res_err`=0; state IDLE.
- Scan trigger: `start` pulse, or `auto` high, in IDLE with `chan_mask`≠0.
  - `chan_mask` and `diff_mask` are latched at acceptance; later changes affect only the next scan.
  - `start` while busy is ignored.
  - `chan_mask`=0 is a no-op: no frame, `busy` stays 0.
- Channels are visited in ascending index, skipping unmasked ones.
- States:
  - IDLE → SETUP (CS low, `CLKDIV` cycles) → SHIFT (N = 7+RES SCLK periods) → GAP (CS high, `CS_IDLE` cycles).
  - From GAP: next masked channel → SETUP; else `auto` high → rescan (re-latch masks, SETUP); else → IDLE.
- Command word, 5 bits MSB first: start=1, SGL/DIFF=~`diff_mask`[ch], D2, D1, D0.
  - D2 is forced 0 when `NCH`=4.
  - After the 5th bit `adc_din` is held 0.
- Received bits:
  - Rising edge 6 is the sample period and is ignored.
  - Rising edge 7 samples the null bit into `res_err`.
  - Rising edges 8..N sample data MSB→LSB into a RES-bit shifter.
- `auto` falling mid-scan: the current scan completes, then IDLE.

## Timing
- Cycle 0 = first cycle with `adc_cs_n` low.
  - `adc_din` carries the start bit from cycle 0.
  - SCLK rising edge k (k=1..N) occurs at cycle `CLKDIV`·(2k−1); falling edge at `CLKDIV`·2k.
- `adc_din` changes only on SCLK falling edges; it is stable across each rising edge.
- `adc_dout`:
  - Passes through a 2-flop synchronizer.
  - Its value is captured `CLKDIV`−1 cycles after each rising edge. This requires CLKDIV≥2 and still lands before the ADC's next falling-edge update.
- At cycle 2N·`CLKDIV`:
  - `adc_cs_n` returns high and `adc_sclk` is low.
  - `res_valid` pulses for one cycle, with `res_chan`/`res_data`/`res_err` updated the same cycle.
  - Result outputs hold until the next strobe.
- Frame-to-frame period is 2N·`CLKDIV`+`CS_IDLE`+`CLKDIV` cycles.
  - 12-bit, defaults: 152+8+4 = 164.
- `busy` falls in the cycle the FSM enters IDLE; a `start` in that same cycle is ignored.
- Reset asserted mid-frame: CS high and SCLK low immediately (asynchronously); no `res_valid` for the aborted frame.

## Structure
- Package `mcp320x_pkg`:
  - FSM state encoding (IDLE, SETUP, SHIFT, GAP).
  - Constants `CMD_BITS`=5, `NULL_EDGE`=7.
  - Function `frame_len(RES)` = 7+RES.
- Sub-module `mcp320x_frame`:
  - Runs one CS-low frame: divider, edge counter, command shifter, receive shifter, null check.
  - Start/done handshake with the scan sequencer in `mcp320x_scan`.

## Test plan
- Bench ADC model returns 12'h111·(ch+1) and checks the command bits.
- One-shot scan, mask 8'hA5, diff 0 → four strobes, channels 0, 2, 5, 7 with 12'h111, 12'h333, 12'h666, 12'h888; `res_err`=0; command for channel 5 is 5'b11101.
- diff_mask 8'h04, mask 8'h04 → command 5'b10010; one strobe, ch 2.
- Period check, defaults → CS low exactly 152 cycles, high ≥8, strobe at cycle 152; `RES`=10, `NCH`=4 → 17 SCLK periods, D2=0.
- Model drives null bit 1 on ch 3 → `res_err`=1 for that strobe only.
- `auto` high, mask 8'h03 → continuous 0, 1, 0, 1…; `start` during busy causes no extra frame; dropping `auto` mid-ch0 ends after ch1.
- `rst_n` low at cycle 60 of a frame → `adc_cs_n`=1 and `adc_sclk`=0 asynchronously; no strobe; mask 0 + `start` → no frame.
